// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: shared widths, saturation constant and FSM state type for
// the zero-crossing frequency meter.
//   SAMPLE_W   - width of the two's-complement DDS sample
//   PERIOD_W   - width of the sample counter / reported period
//   PERIOD_SAT - saturation value of the sample counter
//   state_t    - measurement FSM states (IDLE, PACE, WAIT)
//   sat_inc    - saturating increment for the sample counter
package freq_meter_pkg;

    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned PERIOD_W = 16;

    localparam logic [PERIOD_W-1:0] PERIOD_SAT = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PACE = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    function automatic logic [PERIOD_W-1:0] sat_inc(input logic [PERIOD_W-1:0] v);
        return (v == PERIOD_SAT) ? v : v + PERIOD_W'(1);
    endfunction

endpackage

// File: rtl/sample_pacer.sv
// sample_pacer: paces sample requests while the meter is in PACE.
//   clk    - clock, rising edge
//   reset  - synchronous active-high reset
//   start  - high for every PACE cycle; low clears the countdown
//   div    - pacing interval; pulse on the (div+1)th consecutive start cycle
//   pulse  - one-cycle sample request
module sample_pacer #(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [DIV_W-1:0] div,
    output logic             pulse
);

    logic [DIV_W-1:0] cnt;

    // '>=' rather than '==' so a div lowered mid-count still ends the interval
    assign pulse = start && (cnt >= div);

    always_ff @(posedge clk) begin
        if (reset || !start || pulse) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/freq_meter.sv
// freq_meter: requests DDS samples at a paced rate, detects positive zero
// crossings with hysteresis and reports the number of samples between
// successive crossings.
//   clk, reset        - clock (rising edge), synchronous active-high reset
//   enable            - run measurement; low returns to IDLE
//   div               - pacing interval (pulse every div+1 PACE cycles)
//   sampling_pulse    - one-cycle request for the next sample
//   new_sample_ready  - DDS strobe qualifying sample (honoured only in WAIT)
//   sample            - two's-complement DDS sample
//   period            - samples between the last two positive crossings
//   period_valid      - one-cycle strobe on period update
//   overrange         - last reported period saturated
//   err_timeout       - sticky flag: a request went unanswered
// Optional: define FREQ_METER_PEAK_EN to add output peak, the largest signed
// sample of the window closed by each reported crossing.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned DIV_W   = 8,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned HYST    = 256
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [DIV_W-1:0]    div,
    output logic                sampling_pulse,
    input  logic                new_sample_ready,
    input  logic [SAMPLE_W-1:0] sample,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid,
    output logic                overrange,
    output logic                err_timeout
`ifdef FREQ_METER_PEAK_EN
    ,
    output logic [SAMPLE_W-1:0] peak
`endif
);

    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic signed [SAMPLE_W-1:0] ARM_LVL = SAMPLE_W'(0 - HYST);

    state_t              state;
    logic [TO_W-1:0]     wait_cnt;
    logic [PERIOD_W-1:0] sample_cnt;
    logic                armed;
    logic                seen_cross;

    logic pace_start;
    logic pace_pulse;
    logic accept;
    logic expire;
    logic arm_hit;
    logic crossing;

    assign pace_start = (state == ST_PACE) && enable && !reset;

    sample_pacer #(
        .DIV_W (DIV_W)
    ) u_pacer (
        .clk   (clk),
        .reset (reset),
        .start (pace_start),
        .div   (div),
        .pulse (pace_pulse)
    );

    assign sampling_pulse = pace_pulse;

    // A strobe on the last WAIT cycle wins over the timeout.
    assign accept   = (state == ST_WAIT) && new_sample_ready && enable && !reset;
    assign expire   = (state == ST_WAIT) && !new_sample_ready && (wait_cnt == TO_LAST);
    assign arm_hit  = $signed(sample) <= ARM_LVL;
    assign crossing = accept && armed && !sample[SAMPLE_W-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            wait_cnt     <= '0;
            sample_cnt   <= '0;
            armed        <= 1'b0;
            seen_cross   <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
            overrange    <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            if (!enable) begin
                // period and overrange deliberately hold across IDLE
                state       <= ST_IDLE;
                wait_cnt    <= '0;
                sample_cnt  <= '0;
                armed       <= 1'b0;
                seen_cross  <= 1'b0;
                err_timeout <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: state <= ST_PACE;
                    ST_PACE: begin
                        if (pace_pulse) begin
                            state    <= ST_WAIT;
                            wait_cnt <= '0;
                        end
                    end
                    ST_WAIT: begin
                        if (new_sample_ready || expire) begin
                            state <= ST_PACE;
                        end else begin
                            wait_cnt <= wait_cnt + TO_W'(1);
                        end
                    end
                    default: state <= ST_IDLE;
                endcase

                if (expire) begin
                    err_timeout <= 1'b1;
                end

                if (accept) begin
                    if (crossing) begin
                        // the crossing sample opens the next window, hence 1
                        armed      <= 1'b0;
                        sample_cnt <= PERIOD_W'(1);
                        seen_cross <= 1'b1;
                        if (seen_cross) begin
                            period       <= sample_cnt;
                            period_valid <= 1'b1;
                            overrange    <= (sample_cnt == PERIOD_SAT);
                        end
                    end else begin
                        sample_cnt <= sat_inc(sample_cnt);
                        if (arm_hit) begin
                            armed <= 1'b1;
                        end
                    end
                end
            end
        end
    end

`ifdef FREQ_METER_PEAK_EN
    localparam logic signed [SAMPLE_W-1:0] SAMPLE_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};

    logic signed [SAMPLE_W-1:0] run_max;
    logic signed [SAMPLE_W-1:0] window_max;

    assign window_max = ($signed(sample) > run_max) ? $signed(sample) : run_max;

    always_ff @(posedge clk) begin
        if (reset) begin
            run_max <= SAMPLE_MIN;
            peak    <= SAMPLE_MIN;
        end else if (!enable) begin
            run_max <= SAMPLE_MIN;
        end else if (accept) begin
            if (crossing) begin
                run_max <= SAMPLE_MIN;
                if (seen_cross) begin
                    peak <= window_max;
                end
            end else begin
                run_max <= window_max;
            end
        end
    end
`endif

endmodule

// File: tb/tb_freq_meter.sv
module tb_freq_meter;

    localparam int unsigned DIV_W   = 8;
    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned HYST    = 256;

    localparam logic [15:0] NEG1000 = 16'hFC18;
    localparam logic [15:0] NEG256  = 16'hFF00;
    localparam logic [15:0] NEG255  = 16'hFF01;
    localparam logic [15:0] NEG100  = 16'hFF9C;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic [DIV_W-1:0] div;
    logic             sampling_pulse;
    logic             new_sample_ready;
    logic [15:0]      sample;
    logic [15:0]      period;
    logic             period_valid;
    logic             overrange;
    logic             err_timeout;
`ifdef FREQ_METER_PEAK_EN
    logic [15:0]      peak;
`endif

    freq_meter #(
        .DIV_W   (DIV_W),
        .TIMEOUT (TIMEOUT),
        .HYST    (HYST)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .div              (div),
        .sampling_pulse   (sampling_pulse),
        .new_sample_ready (new_sample_ready),
        .sample           (sample),
        .period           (period),
        .period_valid     (period_valid),
        .overrange        (overrange),
        .err_timeout      (err_timeout)
`ifdef FREQ_METER_PEAK_EN
        ,
        .peak             (peak)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] smp;
        logic        exp_pv;
        logic [15:0] exp_per;
        logic        exp_ovr;
    } vec_t;

    vec_t vecs[$];

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          pulse_cyc = 0;
    int          prev_cyc;
    int          mark;
    logic        got_pv;
    logic        got_ovr;
    logic [15:0] got_per;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_pulse(input string name, input int limit, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (sampling_pulse) begin
                ok = 1'b1;
                pulse_cyc = cyc;
                return;
            end
            tick();
        end
        total++;
        bad++;
        $display("FAIL %s: no sampling_pulse within %0d cycles", name, limit);
    endtask

    // DDS model: answer the next request 'delay' cycles after the pulse cycle,
    // then capture the outputs in the cycle after the accepting strobe.
    task automatic send_sample(input string name, input logic [15:0] v, input int delay);
        logic ok;
        got_pv  = 1'b0;
        got_per = '0;
        got_ovr = 1'b0;
        wait_pulse(name, 64, ok);
        if (!ok) return;
        repeat (delay) tick();
        new_sample_ready = 1'b1;
        sample = v;
        tick();
        new_sample_ready = 1'b0;
        got_pv  = period_valid;
        got_per = period;
        got_ovr = overrange;
    endtask

    task automatic add(input logic [15:0] s, input logic pv, input logic [15:0] per, input logic ovr);
        vec_t v;
        v.smp = s; v.exp_pv = pv; v.exp_per = per; v.exp_ovr = ovr;
        vecs.push_back(v);
    endtask

    initial begin
        logic ok;

        // square wave: 40 high / 40 low; crossings at 80 (unreported), 160, 240
        for (int b = 0; b < 6; b++) begin
            for (int k = 0; k < 40; k++) begin
                add((b % 2 == 0) ? 16'd1000 : NEG1000, (b * 40 + k) == 160, 16'd80, 1'b0);
            end
        end
        add(16'd1000, 1'b1, 16'd80, 1'b0);
        // hysteresis boundary: -255 does not arm, 0 after it is no crossing
        add(NEG255, 1'b0, 16'd0, 1'b0);
        add(16'd0,  1'b0, 16'd0, 1'b0);
        add(NEG256, 1'b0, 16'd0, 1'b0);
        add(16'd0,  1'b1, 16'd4, 1'b0);
        // noise that never reaches the arm level, then a real crossing
        for (int k = 0; k < 4; k++) begin
            add(NEG100, 1'b0, 16'd0, 1'b0);
            add(16'd50, 1'b0, 16'd0, 1'b0);
        end
        add(NEG1000, 1'b0, 16'd0, 1'b0);
        add(16'd1,   1'b1, 16'd10, 1'b0);

        reset = 1'b1;
        enable = 1'b0;
        new_sample_ready = 1'b0;
        sample = '0;
        div = 8'd5;
        repeat (3) tick();
        check("rst_pulse", sampling_pulse, 1'b0);
        check("rst_period", period, 16'd0);
        check("rst_pv", period_valid, 1'b0);
        check("rst_ovr", overrange, 1'b0);
        check("rst_err", err_timeout, 1'b0);

        // pacing cadence, div=5, DDS answers one cycle after each pulse
        reset = 1'b0;
        tick();
        enable = 1'b1;
        mark = cyc;
        wait_pulse("first_pulse", 64, ok);
        check("first_pulse_delay", pulse_cyc - mark, 6);
        tick();
        check("pulse_width", sampling_pulse, 1'b0);
        new_sample_ready = 1'b1;
        tick();
        new_sample_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            prev_cyc = pulse_cyc;
            send_sample("cadence", 16'd0, 1);
            check($sformatf("cadence%0d", i), pulse_cyc - prev_cyc, 7);
        end

        // table-driven crossing / period vectors
        div = 8'd1;
        foreach (vecs[i]) begin
            send_sample("vec", vecs[i].smp, 1);
            check($sformatf("vec%0d_pv", i), got_pv, vecs[i].exp_pv);
            if (vecs[i].exp_pv) begin
                check($sformatf("vec%0d_period", i), got_per, vecs[i].exp_per);
                check($sformatf("vec%0d_ovr", i), got_ovr, vecs[i].exp_ovr);
                tick();
                check($sformatf("vec%0d_pv_drop", i), period_valid, 1'b0);
            end
        end

        // IDLE holds period; first crossing after IDLE is not reported
        enable = 1'b0;
        repeat (2) tick();
        check("idle_period_hold", period, 16'd10);
        check("idle_pulse", sampling_pulse, 1'b0);
        enable = 1'b1;
        send_sample("re_arm", NEG1000, 1);
        send_sample("re_first", 16'd5, 1);
        check("re_first_pv", got_pv, 1'b0);

        // saturation: counter preloaded near the top, then +5 held
        force dut.sample_cnt = 16'hFFF0;
        send_sample("sat_hold", 16'd5, 1);
        release dut.sample_cnt;
        for (int i = 0; i < 19; i++) begin
            send_sample("sat_hold", 16'd5, 1);
            check($sformatf("sat_hold%0d_pv", i), got_pv, 1'b0);
        end
        send_sample("sat_arm", NEG1000, 1);
        send_sample("sat_cross", 16'd5, 1);
        check("sat_pv", got_pv, 1'b1);
        check("sat_period", got_per, 16'hFFFF);
        check("sat_ovr", got_ovr, 1'b1);
        for (int i = 0; i < 3; i++) send_sample("post_sat", NEG1000, 1);
        send_sample("post_sat_cross", 16'd5, 1);
        check("post_sat_period", got_per, 16'd4);
        check("post_sat_ovr", got_ovr, 1'b0);

        // unanswered request: error 16 cycles after the pulse, pacing continues
        enable = 1'b0;
        tick();
        div = 8'd3;
        enable = 1'b1;
        wait_pulse("to_pulse", 64, ok);
        mark = pulse_cyc;
        repeat (16) tick();
        check("to_err_early", err_timeout, 1'b0);
        tick();
        check("to_err_rise", err_timeout, 1'b1);
        wait_pulse("to_next", 64, ok);
        check("to_next_pulse", pulse_cyc - mark, 20);
        check("to_err_sticky", err_timeout, 1'b1);
        new_sample_ready = 1'b1;
        tick();
        new_sample_ready = 1'b0;

        // IDLE clears the error; ready on the timeout's last cycle is accepted
        enable = 1'b0;
        repeat (2) tick();
        check("idle_err_clear", err_timeout, 1'b0);
        enable = 1'b1;
        send_sample("edge_arm", NEG1000, 1);
        send_sample("edge_first", 16'd5, 1);
        check("edge_first_pv", got_pv, 1'b0);
        send_sample("edge_arm2", NEG1000, 1);
        send_sample("edge_late", 16'd5, 16);
        check("edge_pv", got_pv, 1'b1);
        check("edge_period", got_per, 16'd2);
        check("edge_err", err_timeout, 1'b0);

        // enable dropped in WAIT; late ready is ignored
        div = 8'd2;
        wait_pulse("en_pulse", 64, ok);
        tick();
        enable = 1'b0;
        tick();
        new_sample_ready = 1'b1;
        sample = 16'd5;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("en_off_pulse%0d", i), sampling_pulse, 1'b0);
            check($sformatf("en_off_pv%0d", i), period_valid, 1'b0);
            tick();
        end
        enable = 1'b1;
        mark = cyc;
        wait_pulse("en_restart", 64, ok);
        new_sample_ready = 1'b0;
        check("en_restart_delay", pulse_cyc - mark, 3);

        // reset in WAIT drops the request; ready during/after reset ignored
        tick();
        reset = 1'b1;
        new_sample_ready = 1'b1;
        check("rw_pulse_in_reset", sampling_pulse, 1'b0);
        tick();
        check("rw_period", period, 16'd0);
        check("rw_pv", period_valid, 1'b0);
        check("rw_err", err_timeout, 1'b0);
        check("rw_pulse", sampling_pulse, 1'b0);
        reset = 1'b0;
        mark = cyc;
        wait_pulse("rw_restart", 64, ok);
        new_sample_ready = 1'b0;
        check("rw_restart_delay", pulse_cyc - mark, 3);
        check("rw_restart_pv", period_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
